// File: rtl/csr_rmw_sequencer.sv
// Zicsr read-modify-write sequencer: arbitrates requesters onto a single-port
// CSR storage, performs the RW/RS/RC update, applies privilege/read-only checks
// and returns the old CSR value.
module csr_rmw_sequencer #(
  parameter  int XLEN = 64,
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*3-1:0]    req_op,
  input  logic [NREQ*12-1:0]   req_addr,
  input  logic [NREQ*5-1:0]    req_src,
  input  logic [NREQ*XLEN-1:0] req_rs1_val,
  input  logic [NREQ-1:0]      req_rd_zero,
  input  logic [1:0]           cur_priv,
  output logic                 csr_rd_en,
  output logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      csr_rd_data,
  input  logic                 csr_absent,
  output logic                 csr_wr_en,
  output logic [XLEN-1:0]      csr_wr_data,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [XLEN-1:0]      resp_rd_data,
  output logic                 resp_illegal,
  input  logic                 resp_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    MODIFY = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_q;
  logic [2:0]      op_q;
  logic [11:0]     addr_q;
  logic [4:0]      src_q;
  logic [XLEN-1:0] rs1_q;
  logic            skip_rd_q;
  logic            wr_req_q;
  logic            illegal_q;
  logic [XLEN-1:0] old_q;

  logic            any_valid;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;
  logic [2:0]      sel_op;
  logic [11:0]     sel_addr;
  logic [4:0]      sel_src;
  logic [XLEN-1:0] sel_rs1;
  logic            sel_rd_zero;
  logic            sel_rw_form;
  logic            sel_wr_req;
  logic            sel_fail;
  logic            accept;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;

  // Round-robin pick: first valid port starting at rr_ptr, wrapping around.
  always_comb begin
    any_valid = 1'b0;
    gnt_idx   = '0;
    cand      = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        gnt_idx   = cand;
      end
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // Select the winning port's fields and evaluate the accept-time legality checks.
  always_comb begin
    sel_op      = '0;
    sel_addr    = '0;
    sel_src     = '0;
    sel_rs1     = '0;
    sel_rd_zero = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_op      = req_op[i*3 +: 3];
        sel_addr    = req_addr[i*12 +: 12];
        sel_src     = req_src[i*5 +: 5];
        sel_rs1     = req_rs1_val[i*XLEN +: XLEN];
        sel_rd_zero = req_rd_zero[i];
      end
    end
    sel_rw_form = (sel_op[1:0] == 2'b01);
    sel_wr_req  = sel_rw_form || (sel_src != 5'd0);
    sel_fail    = (sel_addr[9:8] > cur_priv) ||
                  ((sel_addr[11:10] == 2'b11) && sel_wr_req);
    accept      = (state == IDLE) && any_valid;
  end

  // Compute the value to write back from the captured old value.
  always_comb begin
    operand = op_q[2] ? {{(XLEN-5){1'b0}}, src_q} : rs1_q;
    case (op_q[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_q | operand;
      2'b11:   new_val = old_q & ~operand;
      default: new_val = old_q;
    endcase
  end

  // State register, arbitration pointer and per-op context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      rs1_q     <= '0;
      skip_rd_q <= 1'b0;
      wr_req_q  <= 1'b0;
      illegal_q <= 1'b0;
      old_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        id_q      <= gnt_idx;
        op_q      <= sel_op;
        addr_q    <= sel_addr;
        src_q     <= sel_src;
        rs1_q     <= sel_rs1;
        skip_rd_q <= sel_rw_form && sel_rd_zero;
        wr_req_q  <= sel_wr_req;
        illegal_q <= sel_fail;
        old_q     <= '0;
      end else if (state == MODIFY) begin
        if (csr_absent) begin
          illegal_q <= 1'b1;
          old_q     <= '0;
        end else begin
          old_q <= skip_rd_q ? '0 : csr_rd_data;
        end
      end
    end
  end

  // Next-state logic and all output strobes.
  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    csr_rd_en    = 1'b0;
    csr_addr     = '0;
    csr_wr_en    = 1'b0;
    csr_wr_data  = '0;
    resp_valid   = 1'b0;
    resp_id      = '0;
    resp_rd_data = '0;
    resp_illegal = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready[gnt_idx] = 1'b1;
          state_nxt          = sel_fail ? RESP : READ;
        end
      end
      READ: begin
        csr_addr  = addr_q;
        csr_rd_en = !skip_rd_q;
        state_nxt = MODIFY;
      end
      MODIFY: begin
        state_nxt = csr_absent ? RESP : WRITE;
      end
      WRITE: begin
        csr_addr  = addr_q;
        if (wr_req_q) begin
          csr_wr_en   = 1'b1;
          csr_wr_data = new_val;
        end
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_id      = id_q;
        resp_rd_data = old_q;
        resp_illegal = illegal_q;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
